bus_arbiter: RTL and testbench

- Sequences 68000 bus-mastership handover (BR/BG/BGACK protocol) on behalf of up to NREQ on-board alternate masters, e.g. the monitor DMA and the step/debug engine.
- Grants to one requester at a time, round-robin.
- Bounds hold time with a watchdog.
- Sits beside the bus controller in the top level; the top level inverts outputs to the board's active-low pins.

---
 rtl/bus_arbiter_pkg.sv | 26 ++
 rtl/bus_arbiter_rr_pick.sv | 41 ++++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
//    Shared definitions for the 68000 bus-mastership arbiter:
//    - state_e    : handover FSM state encoding (3-bit)
//    - HOLD_CNT_W : width of the ownership watchdog counter
//    - idx_width  : bits needed to index a requester vector of size n
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQUEST  = 3'd1,
      ST_WAIT_BUS = 3'd2,
      ST_OWN      = 3'd3,
      ST_RELEASE  = 3'd4
   } state_e;

   localparam int HOLD_CNT_W = 8;

   // A single requester still needs a 1-bit index so ports never collapse
   // to zero width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_pick
//    Combinational round-robin picker. Searches the request vector upward
//    starting one above the pointer, wrapping modulo NREQ, and returns the
//    first set position.
//
//    Ports:
//       req   in   NREQ    request vector
//       ptr   in   IDX_W   last-served requester
//       idx   out  IDX_W   winning requester (valid only when valid=1)
//       valid out  1       at least one request is set
// ---------------------------------------------------------------------------
module bus_arbiter_rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int IDX_W = idx_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      logic [IDX_W-1:0] cand;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      // Offsets 1..NREQ visit every requester once; the pointer itself is
      // checked last so the previous owner has lowest priority.
      for (int i = 1; i <= NREQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NREQ);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//    Runs the 68000 BR/BG/BGACK handover on behalf of NREQ on-board
//    alternate masters. One requester owns the bus at a time, chosen
//    round-robin; a watchdog forces release after HOLD_MAX owned cycles.
//    All outputs are registered and active-high; the top level inverts them
//    for the board pins.
//
//    Ports:
//       CPUCLK_IN   in   1     CPU clock, rising edge
//       RESET_n_IN  in   1     asynchronous active-low reset
//       REQ_IN      in   NREQ  level requests, active-high
//       BG_IN       in   1     CPU bus grant
//       AS_IN       in   1     address strobe
//       DTACK_IN    in   1     DTACK as seen on the bus
//       BGACK_IN    in   1     BGACK from any other master
//       BR          out  1     bus request to the CPU
//       BGACK       out  1     bus grant acknowledge from this block
//       GNT         out  NREQ  one-hot grant to the owning requester
//       TIMEOUT     out  1     one-cycle pulse on watchdog release
// ---------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int HOLD_MAX = 255
) (
   input  logic            CPUCLK_IN,
   input  logic            RESET_n_IN,
   input  logic [NREQ-1:0] REQ_IN,
   input  logic            BG_IN,
   input  logic            AS_IN,
   input  logic            DTACK_IN,
   input  logic            BGACK_IN,
   output logic            BR,
   output logic            BGACK,
   output logic [NREQ-1:0] GNT,
   output logic            TIMEOUT
);

   localparam int IDX_W = idx_width(NREQ);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

   state_e                state_q,    state_d;
   logic [IDX_W-1:0]      winner_q,   winner_d;
   logic [IDX_W-1:0]      rr_ptr_q,   rr_ptr_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic                  br_q,       br_d;
   logic                  bgack_q,    bgack_d;
   logic [NREQ-1:0]       gnt_q,      gnt_d;
   logic                  timeout_q,  timeout_d;

   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_valid;
   logic                  req_win;
   logic                  bus_free;

   bus_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req   (REQ_IN),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign req_win  = REQ_IN[winner_q];
   // The previous master has finished its cycle only when nobody is
   // strobing, no DTACK is still on the bus and no other master holds BGACK.
   assign bus_free = !AS_IN && !DTACK_IN && !BGACK_IN;

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               winner_d = pick_idx;
               state_d  = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (!req_win) begin
               state_d = ST_IDLE;
            end else if (BG_IN) begin
               state_d = ST_WAIT_BUS;
            end
         end
         ST_WAIT_BUS: begin
            // Once BG has been seen the handover is committed; a dropped
            // request is handled by releasing straight out of OWN.
            if (bus_free) begin
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (!req_win) begin
               state_d = ST_RELEASE;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d   = ST_RELEASE;
               timeout_d = 1'b1;
            end
         end
         ST_RELEASE: begin
            rr_ptr_d   = winner_q;
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet
   // line up with the state they belong to.
   always_comb begin
      br_d    = (state_d == ST_REQUEST) || (state_d == ST_WAIT_BUS);
      bgack_d = (state_d == ST_OWN);
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
         assign gnt_d[gi] = (state_d == ST_OWN) && (winner_d == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
      if (!RESET_n_IN) begin
         state_q    <= ST_IDLE;
         winner_q   <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
         br_q       <= 1'b0;
         bgack_q    <= 1'b0;
         gnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         br_q       <= br_d;
         bgack_q    <= bgack_d;
         gnt_q      <= gnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign BR      = br_q;
   assign BGACK   = bgack_q;
   assign GNT     = gnt_q;
   assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//    Directed bench for bus_arbiter. Two instances share clock, reset and
//    bus-side inputs: dut (HOLD_MAX=255) for the handover scenarios and
//    dut_wd (HOLD_MAX=4) for the watchdog. Observed outputs are packed as
//    {BR, BGACK, GNT[1:0], TIMEOUT}.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req, wd_req;
   logic       bg, as_i, dtack, bgack_in;

   logic       br, bgack, tmo;
   logic [1:0] gnt;
   logic       wd_br, wd_bgack, wd_tmo;
   logic [1:0] wd_gnt;

   logic [4:0] obs, wd_obs;
   assign obs    = {br, bgack, gnt, tmo};
   assign wd_obs = {wd_br, wd_bgack, wd_gnt, wd_tmo};

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.NREQ(2), .HOLD_MAX(255)) dut (
      .CPUCLK_IN  (clk),
      .RESET_n_IN (rst_n),
      .REQ_IN     (req),
      .BG_IN      (bg),
      .AS_IN      (as_i),
      .DTACK_IN   (dtack),
      .BGACK_IN   (bgack_in),
      .BR         (br),
      .BGACK      (bgack),
      .GNT        (gnt),
      .TIMEOUT    (tmo)
   );

   bus_arbiter #(.NREQ(2), .HOLD_MAX(4)) dut_wd (
      .CPUCLK_IN  (clk),
      .RESET_n_IN (rst_n),
      .REQ_IN     (wd_req),
      .BG_IN      (bg),
      .AS_IN      (as_i),
      .DTACK_IN   (dtack),
      .BGACK_IN   (bgack_in),
      .BR         (wd_br),
      .BGACK      (wd_bgack),
      .GNT        (wd_gnt),
      .TIMEOUT    (wd_tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 2'b00; wd_req = 2'b00;
      bg = 1'b0; as_i = 1'b0; dtack = 1'b0; bgack_in = 1'b0;
      #2;
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL rst_main got=%b want=%b", obs, 5'b00000); end
      n_cmp++; if (wd_obs !== 5'b00000) begin n_mis++; $display("FAIL rst_wd got=%b want=%b", wd_obs, 5'b00000); end
      tick(); rst_n = 1'b1;
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL rst_idle got=%b want=%b", obs, 5'b00000); end
      $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   task automatic test_single_grant();
      req = 2'b01;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL sg_br_rise got=%b want=%b", obs, 5'b10000); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL sg_br_hold got=%b want=%b", obs, 5'b10000); end
      end
      bg = 1'b1;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL sg_wait_bus got=%b want=%b", obs, 5'b10000); end
      tick();
      n_cmp++; if (obs !== 5'b01010) begin n_mis++; $display("FAIL sg_own got=%b want=%b", obs, 5'b01010); end
      tick();
      n_cmp++; if (obs !== 5'b01010) begin n_mis++; $display("FAIL sg_own_hold got=%b want=%b", obs, 5'b01010); end
      bg = 1'b0; req = 2'b00;
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL sg_release got=%b want=%b", obs, 5'b00000); end
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL sg_idle got=%b want=%b", obs, 5'b00000); end
      $display("test_single_grant done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   task automatic test_bus_busy();
      as_i = 1'b1; req = 2'b10;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL bb_request got=%b want=%b", obs, 5'b10000); end
      bg = 1'b1;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL bb_wait got=%b want=%b", obs, 5'b10000); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL bb_as_busy[%0d] got=%b want=%b", i, obs, 5'b10000); end
      end
      as_i = 1'b0; dtack = 1'b1;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL bb_dtack got=%b want=%b", obs, 5'b10000); end
      dtack = 1'b0; bgack_in = 1'b1;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL bb_ext_bgack got=%b want=%b", obs, 5'b10000); end
      bgack_in = 1'b0;
      tick();
      n_cmp++; if (obs !== 5'b01100) begin n_mis++; $display("FAIL bb_own got=%b want=%b", obs, 5'b01100); end
      bg = 1'b0; req = 2'b00;
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL bb_release got=%b want=%b", obs, 5'b00000); end
      tick();
      $display("test_bus_busy done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   // Pointer is 1 on entry, so requester 0 is served first.
   task automatic test_round_robin();
      logic [1:0] g;
      logic [4:0] want;
      bg = 1'b1; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         g    = (k % 2 == 0) ? 2'b01 : 2'b10;
         want = {2'b01, g, 1'b0};
         tick();
         n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL rr_request[%0d] got=%b want=%b", k, obs, 5'b10000); end
         tick();
         n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL rr_wait[%0d] got=%b want=%b", k, obs, 5'b10000); end
         for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (obs !== want) begin n_mis++; $display("FAIL rr_own[%0d.%0d] got=%b want=%b", k, c, obs, want); end
         end
         req = 2'b11 & ~g;
         tick();
         n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL rr_release[%0d] got=%b want=%b", k, obs, 5'b00000); end
         req = 2'b11;
         tick();
         n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL rr_idle[%0d] got=%b want=%b", k, obs, 5'b00000); end
      end
      req = 2'b00; bg = 1'b0;
      tick();
      $display("test_round_robin done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   task automatic test_watchdog();
      bg = 1'b1; wd_req = 2'b01;
      tick();
      n_cmp++; if (wd_obs !== 5'b10000) begin n_mis++; $display("FAIL wd_request got=%b want=%b", wd_obs, 5'b10000); end
      wd_req = 2'b11;
      tick();
      n_cmp++; if (wd_obs !== 5'b10000) begin n_mis++; $display("FAIL wd_wait got=%b want=%b", wd_obs, 5'b10000); end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++; if (wd_obs !== 5'b01010) begin n_mis++; $display("FAIL wd_own[%0d] got=%b want=%b", c, wd_obs, 5'b01010); end
      end
      tick();
      n_cmp++; if (wd_obs !== 5'b00001) begin n_mis++; $display("FAIL wd_timeout got=%b want=%b", wd_obs, 5'b00001); end
      tick();
      n_cmp++; if (wd_obs !== 5'b00000) begin n_mis++; $display("FAIL wd_pulse_end got=%b want=%b", wd_obs, 5'b00000); end
      tick();
      n_cmp++; if (wd_obs !== 5'b10000) begin n_mis++; $display("FAIL wd_rerequest got=%b want=%b", wd_obs, 5'b10000); end
      tick();
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++; if (wd_obs !== 5'b01100) begin n_mis++; $display("FAIL wd_next_grant[%0d] got=%b want=%b", c, wd_obs, 5'b01100); end
      end
      // Request drop on the last allowed cycle: normal release, no pulse.
      wd_req = 2'b00;
      tick();
      n_cmp++; if (wd_obs !== 5'b00000) begin n_mis++; $display("FAIL wd_drop_wins got=%b want=%b", wd_obs, 5'b00000); end
      bg = 1'b0;
      tick();
      $display("test_watchdog done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   task automatic test_abort();
      req = 2'b01;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL ab_br_rise got=%b want=%b", obs, 5'b10000); end
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL ab_br_hold got=%b want=%b", obs, 5'b10000); end
      req = 2'b00;
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL ab_br_fall got=%b want=%b", obs, 5'b00000); end
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL ab_idle got=%b want=%b", obs, 5'b00000); end
      $display("test_abort done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   // Pointer is still 1 here (abort does not rotate), so requester 0 wins;
   // after reset the pointer is 0 and requester 1 must win.
   task automatic test_async_reset();
      bg = 1'b1; req = 2'b01;
      tick(); tick(); tick();
      n_cmp++; if (obs !== 5'b01010) begin n_mis++; $display("FAIL ar_own got=%b want=%b", obs, 5'b01010); end
      #3; rst_n = 1'b0; req = 2'b00;
      #1;
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL ar_async_drop got=%b want=%b", obs, 5'b00000); end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (obs !== 5'b00000) begin n_mis++; $display("FAIL ar_idle got=%b want=%b", obs, 5'b00000); end
      req = 2'b11;
      tick();
      n_cmp++; if (obs !== 5'b10000) begin n_mis++; $display("FAIL ar_request got=%b want=%b", obs, 5'b10000); end
      tick(); tick();
      n_cmp++; if (obs !== 5'b01100) begin n_mis++; $display("FAIL ar_ptr_zero got=%b want=%b", obs, 5'b01100); end
      req = 2'b00; bg = 1'b0;
      tick(); tick();
      $display("test_async_reset done: compared=%0d mismatched=%0d", n_cmp, n_mis);
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_bus_busy();
      test_round_robin();
      test_watchdog();
      test_abort();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit got=running want=finished");
      $fatal(1, "time limit");
   end

endmodule
